// File: rtl/solver_dispatch_pkg.sv
// Shared types and constants for the solver dispatcher slice.
//   main_state_t   : job intake FSM (IDLE -> LOAD -> START)
//   slot_state_t   : per-solver slot lifecycle (FREE -> LAUNCH -> RUN -> DONE)
//   ITER_SATURATED : iteration count a solver reports when it hits the limit
package solver_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        START
    } main_state_t;

    typedef enum logic [1:0] {
        FREE,
        LAUNCH,
        RUN,
        DONE
    } slot_state_t;

    localparam logic [15:0] ITER_SATURATED = 16'hFFFF;

endpackage

// File: rtl/solver_dispatch_if.sv
// Host-side bundle of the solver dispatcher: config write, job header,
// limb stream and result return.
//   master : host side (drives requests, consumes results)
//   slave  : dispatcher side
interface solver_dispatch_if #(
    parameter int LIMB_INDEX_BITS = 6,
    parameter int LIMB_BITS       = 32,
    parameter int TAG_BITS        = 16
) ();

    logic                       cfg_valid;
    logic                       cfg_ready;
    logic [LIMB_INDEX_BITS-1:0] cfg_num_limbs;
    logic [15:0]                cfg_iter_lim;

    logic                       job_valid;
    logic                       job_ready;
    logic [TAG_BITS-1:0]        job_tag;

    logic                       limb_valid;
    logic                       limb_ready;
    logic [2*LIMB_BITS-1:0]     limb_data;

    logic                       res_valid;
    logic                       res_ready;
    logic [TAG_BITS-1:0]        res_tag;
    logic [15:0]                res_count;

    modport master (
        output cfg_valid, cfg_num_limbs, cfg_iter_lim,
        output job_valid, job_tag,
        output limb_valid, limb_data,
        output res_ready,
        input  cfg_ready, job_ready, limb_ready,
        input  res_valid, res_tag, res_count
    );

    modport slave (
        input  cfg_valid, cfg_num_limbs, cfg_iter_lim,
        input  job_valid, job_tag,
        input  limb_valid, limb_data,
        input  res_ready,
        output cfg_ready, job_ready, limb_ready,
        output res_valid, res_tag, res_count
    );

endinterface

// File: rtl/solver_dispatch_rr_pick.sv
// Round-robin picker: first set bit of req at or after ptr, wrapping.
//   req   : request vector
//   ptr   : starting position (0..N-1)
//   grant : one-hot winner
//   idx   : winner index
//   any   : at least one request present
module rr_pick #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic         any
);

    always_comb begin
        int unsigned j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(ptr) + k) % N;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = W'(j);
            end
        end
    end

endmodule

// File: rtl/solver_dispatch.sv
// Dispatches tagged pixel jobs across NUM_SOLVERS Mandelbrot solvers,
// streams each job's c limbs (highest index first), pulses start, and
// returns tagged iteration counts in round-robin order. Config is broadcast
// only while every solver is idle.
//   clock, reset   : clock, async active-high reset (shared with solvers)
//   host           : config / job / limb / result handshakes
//   slv_*          : solver-side write strobes, broadcasts, start and status
module solver_dispatch
    import solver_pkg::*;
#(
    parameter int NUM_SOLVERS     = 4,
    parameter int LIMB_INDEX_BITS = 6,
    parameter int LIMB_BITS       = 32,
    parameter int TAG_BITS        = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    solver_dispatch_if.slave           host,
    output logic [NUM_SOLVERS-1:0]     slv_wr_en,
    output logic [LIMB_INDEX_BITS-1:0] slv_limb_ind,
    output logic [2*LIMB_BITS-1:0]     slv_limb_data,
    output logic                       slv_num_limbs_en,
    output logic [LIMB_INDEX_BITS-1:0] slv_num_limbs,
    output logic                       slv_iter_lim_en,
    output logic [15:0]                slv_iter_lim,
    output logic [NUM_SOLVERS-1:0]     slv_start,
    input  logic [NUM_SOLVERS-1:0]     slv_out_ready,
    input  logic [16*NUM_SOLVERS-1:0]  slv_iter_count
);

    localparam int SLOT_BITS = $clog2(NUM_SOLVERS);

    main_state_t                state;
    slot_state_t                slot_q  [NUM_SOLVERS];
    logic [TAG_BITS-1:0]        tag_q   [NUM_SOLVERS];
    logic [15:0]                count_q [NUM_SOLVERS];
    logic [LIMB_INDEX_BITS-1:0] num_limbs;
    logic [LIMB_INDEX_BITS-1:0] index;
    logic [NUM_SOLVERS-1:0]     job_grant_q;
    logic [NUM_SOLVERS-1:0]     res_grant_q;
    logic [SLOT_BITS-1:0]       job_ptr;
    logic [SLOT_BITS-1:0]       res_ptr;
    logic [SLOT_BITS-1:0]       res_slot;
    logic                       res_valid_q;
    logic [TAG_BITS-1:0]        res_tag_q;
    logic [15:0]                res_count_q;

    logic [NUM_SOLVERS-1:0]     free_vec, done_vec, done_req;
    logic [NUM_SOLVERS-1:0]     job_grant, res_grant;
    logic [SLOT_BITS-1:0]       job_idx, res_idx, res_ptr_eff;
    logic                       any_free, any_done, all_free;
    logic                       cfg_fire, job_fire, limb_fire, res_fire, res_load;

    function automatic logic [SLOT_BITS-1:0] next_slot(input logic [SLOT_BITS-1:0] s);
        return (int'(s) == NUM_SOLVERS - 1) ? '0 : s + SLOT_BITS'(1);
    endfunction

    always_comb begin
        free_vec = '0;
        done_vec = '0;
        for (int unsigned i = 0; i < NUM_SOLVERS; i++) begin
            free_vec[i] = (slot_q[i] == FREE);
            done_vec[i] = (slot_q[i] == DONE);
        end
    end

    assign all_free = &free_vec;

    // Host handshakes. reset gating keeps every output low while reset is held.
    assign host.cfg_ready  = !reset && (state == IDLE) && all_free;
    assign host.job_ready  = !reset && (state == IDLE) && host.job_valid && any_free && !host.cfg_valid;
    assign host.limb_ready = (state == LOAD);
    assign cfg_fire        = host.cfg_valid && host.cfg_ready;
    assign job_fire        = host.job_ready;
    assign limb_fire       = host.limb_ready && host.limb_valid;

    assign slv_wr_en     = limb_fire ? job_grant_q : '0;
    assign slv_limb_ind  = (state == LOAD) ? index : '0;
    assign slv_limb_data = (state == LOAD) ? host.limb_data : '0;
    assign slv_start     = (state == START) ? job_grant_q : '0;

    // The slot on the result port stays DONE until its handshake edge, so it
    // is masked out; on a handshake the search starts past it so results can
    // issue back-to-back.
    assign res_fire    = res_valid_q && host.res_ready;
    assign done_req    = done_vec & ~(res_valid_q ? res_grant_q : '0);
    assign res_ptr_eff = res_fire ? next_slot(res_slot) : res_ptr;
    assign res_load    = (!res_valid_q || res_fire) && any_done;

    assign host.res_valid = res_valid_q;
    assign host.res_tag   = res_tag_q;
    assign host.res_count = res_count_q;

    rr_pick #(.N(NUM_SOLVERS)) u_job_pick (
        .req   (free_vec),
        .ptr   (job_ptr),
        .grant (job_grant),
        .idx   (job_idx),
        .any   (any_free)
    );

    rr_pick #(.N(NUM_SOLVERS)) u_res_pick (
        .req   (done_req),
        .ptr   (res_ptr_eff),
        .grant (res_grant),
        .idx   (res_idx),
        .any   (any_done)
    );

    // Main FSM plus config broadcast.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            num_limbs        <= LIMB_INDEX_BITS'(1);
            index            <= '0;
            job_ptr          <= '0;
            job_grant_q      <= '0;
            slv_num_limbs_en <= 1'b0;
            slv_num_limbs    <= '0;
            slv_iter_lim_en  <= 1'b0;
            slv_iter_lim     <= '0;
            for (int unsigned i = 0; i < NUM_SOLVERS; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            slv_num_limbs_en <= 1'b0;
            slv_iter_lim_en  <= 1'b0;
            if (cfg_fire) begin
                slv_iter_lim_en <= 1'b1;
                slv_iter_lim    <= host.cfg_iter_lim;
                // A zero limb count would leave the solvers unusable; drop it.
                if (host.cfg_num_limbs != '0) begin
                    num_limbs        <= host.cfg_num_limbs;
                    slv_num_limbs_en <= 1'b1;
                    slv_num_limbs    <= host.cfg_num_limbs;
                end
            end
            unique case (state)
                IDLE: begin
                    if (job_fire) begin
                        state          <= LOAD;
                        job_grant_q    <= job_grant;
                        job_ptr        <= next_slot(job_idx);
                        index          <= num_limbs - LIMB_INDEX_BITS'(1);
                        tag_q[job_idx] <= host.job_tag;
                    end
                end
                LOAD: begin
                    if (limb_fire) begin
                        if (index == '0) state <= START;
                        else             index <= index - LIMB_INDEX_BITS'(1);
                    end
                end
                START:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Slot lifecycle and result arbiter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_SOLVERS; i++) begin
                slot_q[i]  <= FREE;
                count_q[i] <= '0;
            end
            res_ptr     <= '0;
            res_slot    <= '0;
            res_grant_q <= '0;
            res_valid_q <= 1'b0;
            res_tag_q   <= '0;
            res_count_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_SOLVERS; i++) begin
                unique case (slot_q[i])
                    FREE:   if (state == START && job_grant_q[i]) slot_q[i] <= LAUNCH;
                    // out_ready is still high from the previous job here.
                    LAUNCH: slot_q[i] <= RUN;
                    RUN: begin
                        if (slv_out_ready[i]) begin
                            slot_q[i]  <= DONE;
                            count_q[i] <= slv_iter_count[16*i +: 16];
                        end
                    end
                    DONE:    if (res_fire && res_grant_q[i]) slot_q[i] <= FREE;
                    default: slot_q[i] <= FREE;
                endcase
            end
            if (res_fire) res_ptr <= next_slot(res_slot);
            if (res_load) begin
                res_valid_q <= 1'b1;
                res_slot    <= res_idx;
                res_grant_q <= res_grant;
                res_tag_q   <= tag_q[res_idx];
                res_count_q <= count_q[res_idx];
            end else if (res_fire) begin
                res_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_solver_dispatch.sv
// Directed bench for solver_dispatch with a 4-solver behavioural model.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_solver_dispatch;
    import solver_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  slv_wr_en, slv_start;
    logic [5:0]  slv_limb_ind, slv_num_limbs;
    logic [63:0] slv_limb_data;
    logic        slv_num_limbs_en, slv_iter_lim_en;
    logic [15:0] slv_iter_lim;
    logic [3:0]  slv_out_ready;
    logic [63:0] slv_iter_count = '0;
    logic [3:0]  release_mask = '0;
    logic [3:0]  busy;
    logic        res_seen;

    int n_checks = 0;
    int n_fail   = 0;

    solver_dispatch_if #(.LIMB_INDEX_BITS(6), .LIMB_BITS(32), .TAG_BITS(16)) host ();

    solver_dispatch #(
        .NUM_SOLVERS(4), .LIMB_INDEX_BITS(6), .LIMB_BITS(32), .TAG_BITS(16)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .host             (host.slave),
        .slv_wr_en        (slv_wr_en),
        .slv_limb_ind     (slv_limb_ind),
        .slv_limb_data    (slv_limb_data),
        .slv_num_limbs_en (slv_num_limbs_en),
        .slv_num_limbs    (slv_num_limbs),
        .slv_iter_lim_en  (slv_iter_lim_en),
        .slv_iter_lim     (slv_iter_lim),
        .slv_start        (slv_start),
        .slv_out_ready    (slv_out_ready),
        .slv_iter_count   (slv_iter_count)
    );

    always #5 clock = ~clock;

    // Solver model: out_ready idles high, drops on start, rises again one
    // cycle after the bench releases that solver.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            slv_out_ready <= '1;
            busy          <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (slv_start[i]) begin
                    busy[i]          <= 1'b1;
                    slv_out_ready[i] <= 1'b0;
                end else if (busy[i] && release_mask[i]) begin
                    busy[i]          <= 1'b0;
                    slv_out_ready[i] <= 1'b1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_res();
        int w = 0;
        while (!host.res_valid && w < 50) begin
            @(negedge clock); #1;
            w++;
        end
        check("res_valid", host.res_valid, 1'b1);
    endtask

    task automatic accept_res(input logic [15:0] tag, input logic [15:0] cnt);
        wait_res();
        check("res_tag", host.res_tag, tag);
        check("res_count", host.res_count, cnt);
        host.res_ready = 1'b1;
        @(negedge clock);
        host.res_ready = 1'b0;
        #1;
    endtask

    task automatic do_job(input logic [15:0] tag, input int slot, input int n, input bit gap);
        int w = 0;
        @(negedge clock);
        host.job_valid = 1'b1;
        host.job_tag   = tag;
        #1;
        while (!host.job_ready && w < 100) begin
            @(negedge clock); #1;
            w++;
        end
        check("job_ready", host.job_ready, 1'b1);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            host.job_valid = 1'b0;
            if (gap) begin
                host.limb_valid = 1'b0;
                #1;
                check("gap_wr_en", slv_wr_en, 4'b0000);
                @(negedge clock);
            end
            host.limb_valid = 1'b1;
            host.limb_data  = {tag, 16'h0, 32'(k)};
            #1;
            check("limb_ready", host.limb_ready, 1'b1);
            check("wr_en", slv_wr_en, 4'b0001 << slot);
            check("limb_ind", slv_limb_ind, 6'(n - 1 - k));
            check("limb_data", slv_limb_data, {tag, 16'h0, 32'(k)});
        end
        @(negedge clock);
        host.limb_valid = 1'b0;
        #1;
        check("start", slv_start, 4'b0001 << slot);
        @(negedge clock); #1;
        check("start_off", slv_start, 4'b0000);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("rst_res_valid", host.res_valid, 1'b0);
        check("rst_cfg_ready", host.cfg_ready, 1'b0);
        check("rst_start", slv_start, 4'b0000);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_cfg_ready_after", host.cfg_ready, 1'b1);
    endtask

    task automatic do_cfg(input logic [5:0] nl, input logic [15:0] lim, input bit exp_ready);
        @(negedge clock);
        host.cfg_valid     = 1'b1;
        host.cfg_num_limbs = nl;
        host.cfg_iter_lim  = lim;
        #1;
        check("cfg_ready", host.cfg_ready, exp_ready);
        @(negedge clock);
        host.cfg_valid = 1'b0;
        #1;
        check("num_limbs_en", slv_num_limbs_en, exp_ready && nl != 0);
        check("iter_lim_en", slv_iter_lim_en, exp_ready);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        host.cfg_valid     = 1'b0;
        host.cfg_num_limbs = '0;
        host.cfg_iter_lim  = '0;
        host.job_valid     = 1'b0;
        host.job_tag       = '0;
        host.limb_valid    = 1'b0;
        host.limb_data     = '0;
        host.res_ready     = 1'b0;

        // Reset state and single-job flow
        apply_reset();
        check("rst_job_ready", host.job_ready, 1'b0);
        check("rst_wr_en", slv_wr_en, 4'b0000);
        do_cfg(6'd4, 16'd100, 1'b1);
        check("num_limbs_val", slv_num_limbs, 6'd4);
        check("iter_lim_val", slv_iter_lim, 16'd100);
        do_job(16'h0012, 0, 4, 1'b0);
        slv_iter_count[15:0] = 16'd37;
        release_mask = 4'b0001;
        accept_res(16'h0012, 16'd37);
        release_mask = '0;
        check("res_drop", host.res_valid, 1'b0);

        // Fill all four solvers, fifth job stalls until a slot frees
        apply_reset();
        for (int s = 0; s < 4; s++) do_job(16'h0100 + 16'(s), s, 1, 1'b0);
        @(negedge clock);
        host.job_valid = 1'b1;
        host.job_tag   = 16'h0104;
        #1;
        check("job5_stall", host.job_ready, 1'b0);
        repeat (3) begin
            @(negedge clock); #1;
            check("job5_stall", host.job_ready, 1'b0);
        end
        slv_iter_count[31:16] = 16'd5;
        release_mask = 4'b0010;
        wait_res();
        release_mask = '0;
        check("job5_res_tag", host.res_tag, 16'h0101);
        check("job5_res_count", host.res_count, 16'd5);
        check("job5_hs_stall", host.job_ready, 1'b0);
        host.res_ready = 1'b1;
        @(posedge clock); #1;
        host.res_ready = 1'b0;
        do_job(16'h0104, 1, 1, 1'b0);

        // Result arbitration: solvers 2 and 0 finish together, pointer at 1
        slv_iter_count[15:0] = 16'd99;
        release_mask = 4'b0001;
        accept_res(16'h0100, 16'd99);
        release_mask = '0;
        do_job(16'h0200, 0, 1, 1'b0);
        slv_iter_count[15:0]  = 16'd11;
        slv_iter_count[47:32] = 16'd222;
        release_mask = 4'b0101;
        wait_res();
        release_mask = '0;
        for (int c = 0; c < 10; c++) begin
            check("hold_valid", host.res_valid, 1'b1);
            check("hold_tag", host.res_tag, 16'h0102);
            check("hold_count", host.res_count, 16'd222);
            @(negedge clock); #1;
        end
        host.res_ready = 1'b1;
        @(negedge clock); #1;
        check("b2b_valid", host.res_valid, 1'b1);
        check("b2b_tag", host.res_tag, 16'h0200);
        check("b2b_count", host.res_count, 16'd11);
        @(negedge clock);
        host.res_ready = 1'b0;
        #1;
        check("b2b_drop", host.res_valid, 1'b0);

        // Config blocked while solvers 1 and 3 run
        do_cfg(6'd8, 16'd50, 1'b0);
        slv_iter_count[31:16] = ITER_SATURATED;
        slv_iter_count[63:48] = 16'd33;
        release_mask = 4'b1010;
        accept_res(16'h0104, ITER_SATURATED);
        accept_res(16'h0103, 16'd33);
        release_mask = '0;

        // Zero limb count ignored; gapped limb stream
        do_cfg(6'd3, 16'd60, 1'b1);
        check("num_limbs_3", slv_num_limbs, 6'd3);
        do_cfg(6'd0, 16'd77, 1'b1);
        check("iter_lim_77", slv_iter_lim, 16'd77);
        check("num_limbs_kept", slv_num_limbs, 6'd3);
        do_job(16'h0400, 1, 3, 1'b1);
        slv_iter_count[31:16] = 16'd100;
        release_mask = 4'b0010;
        accept_res(16'h0400, 16'd100);
        release_mask = '0;

        // Reset in the middle of a limb load
        @(negedge clock);
        host.job_valid = 1'b1;
        host.job_tag   = 16'h0500;
        #1;
        check("mid_job_ready", host.job_ready, 1'b1);
        @(negedge clock);
        host.job_valid  = 1'b0;
        host.limb_valid = 1'b1;
        host.limb_data  = 64'h1234;
        #1;
        check("mid_wr_en", slv_wr_en, 4'b0100);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_wr_en", slv_wr_en, 4'b0000);
        check("mid_rst_limb_ready", host.limb_ready, 1'b0);
        check("mid_rst_limb_ind", slv_limb_ind, 6'd0);
        check("mid_rst_limb_data", slv_limb_data, 64'h0);
        check("mid_rst_cfg_ready", host.cfg_ready, 1'b0);
        check("mid_rst_iter_lim", slv_iter_lim, 16'd0);
        @(negedge clock);
        host.limb_valid = 1'b0;
        reset = 1'b0;
        release_mask = '1;
        res_seen = 1'b0;
        repeat (30) begin
            @(negedge clock); #1;
            res_seen = res_seen | host.res_valid;
        end
        check("abandoned_res", res_seen, 1'b0);
        check("post_rst_cfg_ready", host.cfg_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
